// File: rtl/sha256_w_sched_engine.sv
// SHA-256 message-schedule engine: loads a 512-bit block and streams W[0..NUM_ROUNDS-1]
// through valid/ready, WORDS_PER_CYCLE words per handshake, from a 16-word sliding window.
module sha256_w_sched_engine #(
    parameter int unsigned WORDS_PER_CYCLE = 1,
    parameter int unsigned NUM_ROUNDS      = 64
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         start,
    input  logic                         abort,
    input  logic [511:0]                 block_in,
    output logic                         busy,
    output logic                         w_valid,
    input  logic                         w_ready,
    output logic [32*WORDS_PER_CYCLE-1:0] w_out,
    output logic [5:0]                   w_index,
    output logic                         done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - WORDS_PER_CYCLE);
    localparam logic [5:0] STEP     = 6'(WORDS_PER_CYCLE);

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [5:0]  r_index;
    logic        r_done;

    logic [31:0] w_new   [WORDS_PER_CYCLE];
    logic [31:0] w_shift [16];
    logic        w_fire;
    logic        w_last;

    function automatic logic [31:0] f_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Word j only reads window[j..j+14], so both lanes come from registered state.
    for (genvar g = 0; g < WORDS_PER_CYCLE; g++) begin : g_lane
        assign w_new[g] = r_win[g] + f_s0(r_win[g+1]) + r_win[g+9] + f_s1(r_win[g+14]);
        assign w_out[32*g +: 32] = r_win[g];
    end

    for (genvar g = 0; g < 16; g++) begin : g_shift
        if (g < 16 - WORDS_PER_CYCLE) begin : g_keep
            assign w_shift[g] = r_win[g+WORDS_PER_CYCLE];
        end else begin : g_append
            assign w_shift[g] = w_new[g-(16-WORDS_PER_CYCLE)];
        end
    end

    assign busy    = (r_state == RUN);
    assign w_valid = (r_state == RUN);
    assign w_index = r_index;
    assign done    = r_done;
    assign w_fire  = w_valid & w_ready;
    assign w_last  = (r_index == LAST_IDX);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            for (int unsigned i = 0; i < 16; i++) r_win[i] <= '0;
            r_index <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!abort && start) begin
                        for (int unsigned i = 0; i < 16; i++) r_win[i] <= block_in[511-32*i -: 32];
                        r_index <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_fire) begin
                        for (int unsigned i = 0; i < 16; i++) r_win[i] <= w_shift[i];
                        // Index parks on the last group so it never passes NUM_ROUNDS-WORDS_PER_CYCLE.
                        if (w_last) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= r_index + STEP;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_w_sched_engine.sv
// Directed bench for sha256_w_sched_engine: one instance per lane width, checked against
// hand constants and an independent textbook W[t] expansion.
module tb_sha256_w_sched_engine;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;

    logic         start1 = 1'b0, abort1 = 1'b0, ready1 = 1'b0;
    logic [511:0] block1 = '0;
    logic         busy1, valid1, done1;
    logic [31:0]  out1;
    logic [5:0]   idx1;

    logic         start2 = 1'b0, abort2 = 1'b0, ready2 = 1'b0;
    logic [511:0] block2 = '0;
    logic         busy2, valid2, done2;
    logic [63:0]  out2;
    logic [5:0]   idx2;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [31:0]  m_w [64];
    logic [31:0]  got [64];
    logic [511:0] ABC;

    sha256_w_sched_engine #(.WORDS_PER_CYCLE(1), .NUM_ROUNDS(64)) u_dut1 (
        .CLK(CLK), .RST(RST), .start(start1), .abort(abort1), .block_in(block1),
        .busy(busy1), .w_valid(valid1), .w_ready(ready1), .w_out(out1),
        .w_index(idx1), .done(done1)
    );

    sha256_w_sched_engine #(.WORDS_PER_CYCLE(2), .NUM_ROUNDS(64)) u_dut2 (
        .CLK(CLK), .RST(RST), .start(start2), .abort(abort2), .block_in(block2),
        .busy(busy2), .w_valid(valid2), .w_ready(ready2), .w_out(out2),
        .w_index(idx2), .done(done2)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bs0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] bs1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model(input logic [511:0] blk);
        for (int t = 0; t < 16; t++) m_w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) m_w[t] = bs1(m_w[t-2]) + m_w[t-7] + bs0(m_w[t-15]) + m_w[t-16];
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_u1(input logic [511:0] blk);
        start1 = 1'b1;
        block1 = blk;
        tick();
        start1 = 1'b0;
        block1 = {16{32'hDEADBEEF}};
    endtask

    task automatic test_reset();
        RST = 1'b0;
        tick();
        tick();
        n_tests++;
        if ({busy1, valid1, done1, idx1, out1} !== '0) begin
            n_fail++;
            $display("FAIL reset_u1: busy=%b valid=%b done=%b idx=%0d out=%h, required all 0", busy1, valid1, done1, idx1, out1);
        end
        n_tests++;
        if ({busy2, valid2, done2, idx2, out2} !== '0) begin
            n_fail++;
            $display("FAIL reset_u2: busy=%b valid=%b done=%b idx=%0d out=%h, required all 0", busy2, valid2, done2, idx2, out2);
        end
        RST = 1'b1;
        tick();
    endtask

    task automatic test_abc_stream();
        int fires = 0;
        int dones = 0;
        int hidx [7] = '{0, 15, 16, 17, 18, 19, 20};
        logic [31:0] hval [7] = '{32'h61626380, 32'h00000018, 32'h61626380, 32'h000F0000,
                                  32'h7DA86405, 32'h600003C6, 32'h3E9D7B78};
        ready1 = 1'b1;
        start_u1(ABC);
        for (int cyc = 0; cyc < 100 && fires < 64; cyc++) begin
            n_tests++;
            if (valid1 !== 1'b1 || idx1 !== 6'(fires) || out1 !== m_w[fires]) begin
                n_fail++;
                $display("FAIL abc_word: valid=%b idx=%0d out=%h, required valid=1 idx=%0d out=%h", valid1, idx1, out1, fires, m_w[fires]);
            end
            got[fires] = out1;
            tick();
            fires++;
            if (done1) dones++;
        end
        n_tests++;
        if (fires !== 64 || dones !== 1 || done1 !== 1'b1 || valid1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abc_end: fires=%0d dones=%0d done=%b valid=%b busy=%b, required 64 1 1 0 0", fires, dones, done1, valid1, busy1);
        end
        for (int k = 0; k < 7; k++) begin
            n_tests++;
            if (got[hidx[k]] !== hval[k]) begin
                n_fail++;
                $display("FAIL abc_hand W%0d: got %h, required %h", hidx[k], got[hidx[k]], hval[k]);
            end
        end
        tick();
        n_tests++;
        if (done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abc_done_width: done=%b one cycle later, required 0", done1);
        end
    endtask

    task automatic test_stall();
        int fires = 0;
        int dones = 0;
        int stall = 0;
        logic [31:0] prev_out = '0;
        logic [5:0]  prev_idx = '0;
        logic        prev_fire = 1'b1;
        ready1 = 1'b0;
        start_u1(ABC);
        for (int cyc = 0; cyc < 1000 && fires < 64; cyc++) begin
            n_tests++;
            if (valid1 !== 1'b1 || idx1 !== 6'(fires) || out1 !== m_w[fires]) begin
                n_fail++;
                $display("FAIL stall_word: valid=%b idx=%0d out=%h, required valid=1 idx=%0d out=%h", valid1, idx1, out1, fires, m_w[fires]);
            end
            if (!prev_fire) begin
                n_tests++;
                if (out1 !== prev_out || idx1 !== prev_idx) begin
                    n_fail++;
                    $display("FAIL stall_hold: idx=%0d out=%h, required idx=%0d out=%h", idx1, out1, prev_idx, prev_out);
                end
            end
            if (stall > 0) begin
                ready1 = 1'b0;
                stall--;
            end else if ($urandom_range(0, 2) == 0) begin
                ready1 = 1'b0;
                stall = int'($urandom_range(0, 4));
            end else begin
                ready1 = 1'b1;
            end
            prev_out  = out1;
            prev_idx  = idx1;
            prev_fire = ready1;
            tick();
            if (ready1) fires++;
            if (done1) dones++;
        end
        n_tests++;
        if (fires !== 64 || dones !== 1 || done1 !== 1'b1 || valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: fires=%0d dones=%0d done=%b valid=%b, required 64 1 1 0", fires, dones, done1, valid1);
        end
        ready1 = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int fires = 0;
        ready1 = 1'b1;
        start_u1(ABC);
        for (int cyc = 0; cyc < 100 && fires < 64; cyc++) begin
            n_tests++;
            if (idx1 !== 6'(fires) || out1 !== m_w[fires]) begin
                n_fail++;
                $display("FAIL b2b_abc_word: idx=%0d out=%h, required idx=%0d out=%h", idx1, out1, fires, m_w[fires]);
            end
            tick();
            fires++;
        end
        n_tests++;
        if (done1 !== 1'b1 || valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bubble: done=%b valid=%b, required 1 0", done1, valid1);
        end
        start_u1('0);
        fires = 0;
        for (int cyc = 0; cyc < 100 && fires < 64; cyc++) begin
            n_tests++;
            if (valid1 !== 1'b1 || idx1 !== 6'(fires) || out1 !== 32'h0) begin
                n_fail++;
                $display("FAIL zero_word: valid=%b idx=%0d out=%h, required valid=1 idx=%0d out=00000000", valid1, idx1, out1, fires);
            end
            start1 = (fires == 10);
            block1 = ABC;
            tick();
            start1 = 1'b0;
            fires++;
        end
        n_tests++;
        if (done1 !== 1'b1 || valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_end: done=%b valid=%b, required 1 0", done1, valid1);
        end
        tick();
    endtask

    task automatic test_abort();
        ready1 = 1'b1;
        start_u1(ABC);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (idx1 == 6'd20) break;
            n_tests++;
            if (out1 !== m_w[idx1]) begin
                n_fail++;
                $display("FAIL abort_pre_word: idx=%0d out=%h, required %h", idx1, out1, m_w[idx1]);
            end
            tick();
        end
        n_tests++;
        if (idx1 !== 6'd20 || valid1 !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reach: idx=%0d valid=%b, required 20 1", idx1, valid1);
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        n_tests++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: valid=%b busy=%b done=%b, required 0 0 0", valid1, busy1, done1);
        end
        tick();
        n_tests++;
        if (done1 !== 1'b0 || valid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: done=%b valid=%b, required 0 0", done1, valid1);
        end
        start1 = 1'b1;
        abort1 = 1'b1;
        block1 = ABC;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        n_tests++;
        if (valid1 !== 1'b0 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_over_start: valid=%b busy=%b, required 0 0", valid1, busy1);
        end
        start_u1(ABC);
        n_tests++;
        if (valid1 !== 1'b1 || idx1 !== 6'd0 || out1 !== 32'h61626380) begin
            n_fail++;
            $display("FAIL abort_restart: valid=%b idx=%0d out=%h, required 1 0 61626380", valid1, idx1, out1);
        end
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int fires = 0;
        ready1 = 1'b1;
        start_u1(ABC);
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (idx1 == 6'd30) break;
            tick();
        end
        n_tests++;
        if (idx1 !== 6'd30 || out1 !== m_w[30]) begin
            n_fail++;
            $display("FAIL areset_reach: idx=%0d out=%h, required 30 %h", idx1, out1, m_w[30]);
        end
        #2;
        RST = 1'b0;
        #1;
        n_tests++;
        if ({busy1, valid1, done1, idx1, out1} !== '0) begin
            n_fail++;
            $display("FAIL areset_async: busy=%b valid=%b done=%b idx=%0d out=%h, required all 0", busy1, valid1, done1, idx1, out1);
        end
        tick();
        RST = 1'b1;
        tick();
        start_u1(ABC);
        for (int cyc = 0; cyc < 100 && fires < 64; cyc++) begin
            n_tests++;
            if (valid1 !== 1'b1 || idx1 !== 6'(fires) || out1 !== m_w[fires]) begin
                n_fail++;
                $display("FAIL areset_word: valid=%b idx=%0d out=%h, required valid=1 idx=%0d out=%h", valid1, idx1, out1, fires, m_w[fires]);
            end
            tick();
            fires++;
        end
        n_tests++;
        if (done1 !== 1'b1 || fires !== 64) begin
            n_fail++;
            $display("FAIL areset_end: done=%b fires=%0d, required 1 64", done1, fires);
        end
        ready1 = 1'b0;
        tick();
    endtask

    task automatic test_wpc2();
        int fires = 0;
        int dones = 0;
        ready2 = 1'b1;
        start2 = 1'b1;
        block2 = ABC;
        tick();
        start2 = 1'b0;
        block2 = '0;
        for (int cyc = 0; cyc < 100 && fires < 32; cyc++) begin
            n_tests++;
            if (valid2 !== 1'b1 || idx2 !== 6'(2*fires) || out2 !== {m_w[2*fires+1], m_w[2*fires]}) begin
                n_fail++;
                $display("FAIL wpc2_word: valid=%b idx=%0d out=%h, required valid=1 idx=%0d out=%h", valid2, idx2, out2, 2*fires, {m_w[2*fires+1], m_w[2*fires]});
            end
            if (idx2 == 6'd16) begin
                n_tests++;
                if (out2[63:32] !== 32'h000F0000) begin
                    n_fail++;
                    $display("FAIL wpc2_lane1_w17: got %h, required 000f0000", out2[63:32]);
                end
            end
            tick();
            fires++;
            if (done2) dones++;
        end
        n_tests++;
        if (fires !== 32 || dones !== 1 || done2 !== 1'b1 || valid2 !== 1'b0) begin
            n_fail++;
            $display("FAIL wpc2_end: fires=%0d dones=%0d done=%b valid=%b, required 32 1 1 0", fires, dones, done2, valid2);
        end
        ready2 = 1'b0;
        tick();
    endtask

    initial begin
        ABC = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        build_model(ABC);
        test_reset();
        test_abc_stream();
        test_stall();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_wpc2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
